vga_write_arbiter: RTL and testbench
====================================

Name: vga_write_arbiter

Overview:
- Arbitrates the single video-memory write port (X, Y, wr_en, pixel) of the VGA frame-buffer block between NREQ external pixel writers and an internal rectangle-fill engine.
- Optionally holds all writes while the display is in its visible region (tear-free mode).
- Clips out-of-range coordinates against the runtime width/height and drives the frame buffer with registered outputs.

Parameters:
- NREQ, 2, number of external write requesters (1..8).
- COORD_W, 10, coordinate width in bits (matches the frame buffer's 1024x1024 maximum).
- PIX_W, 3, pixel colour width in bits.

Ports:
- clk  in  1  system clock (same clock as the frame buffer's write side).
- srst  in  1  reset, asynchronous, active-high.
- width  in  COORD_W  active display width in pixels.
- height  in  COORD_W  active display height in pixels.
- tear_free  in  1  1 = grant only while visible=0.
- visible  in  1  frame-buffer visible flag, already synchronised to clk.
- req_valid  in  NREQ  per-requester write request.
- req_ready  out  NREQ  per-requester grant; transfer occurs when valid&ready.
- req_x  in  NREQ x COORD_W  requested column.
- req_y  in  NREQ x COORD_W  requested row.
- req_pixel  in  NREQ x PIX_W  requested colour.
- fill_start  in  1  one-cycle command to start a rectangle fill.
- fill_x0, fill_y0, fill_x1, fill_y1  in  COORD_W each  inclusive rectangle corners.
- fill_color  in  PIX_W  fill colour.
- fill_busy  out  1  fill engine active.
- fill_done  out  1  one-cycle pulse marking the last fill write.
- X  out  COORD_W  write column to the frame buffer.
- Y  out  COORD_W  write row to the frame buffer.
- wr_en  out  1  write strobe to the frame buffer.
- pixel  out  PIX_W  write colour to the frame buffer.
- clip_err  out  1  one-cycle pulse for a dropped out-of-range requester write.

Behaviour:
- **Reset.** While srst is high, asynchronously: X=Y=0, pixel=0, wr_en=0, clip_err=0, fill_done=0, fill_busy=0, req_ready=0. The round-robin pointer is set to slot NREQ, so slot 0 has first priority. The fill engine goes to IDLE. A fill in progress is aborted with no fill_done pulse.
- **Slots.** Slots 0..NREQ-1 are the external requesters; slot NREQ is the fill engine. The fill slot is eligible only while fill_busy=1.
- **Grant.**
  - Each cycle, at most one grant is issued.
  - The search starts at slot (ptr+1) mod (NREQ+1) and takes the first eligible slot.
  - The pointer updates only on a grant.
  - No grants are issued when tear_free=1 and visible=1. Pending requesters wait and the fill engine pauses in place.
- **Ready.** req_ready[i] is combinational, asserted the same cycle req_valid[i] is sampled and slot i wins. Requesters must hold their data until ready.
- **Latency.** A grant in cycle N produces wr_en=1 with the matching X/Y/pixel in cycle N+1 (one cycle). wr_en is 0 in every cycle not preceded by a grant. X/Y/pixel hold their last value when wr_en=0.
- **Clipping.**
  - A granted requester write with x>=width or y>=height is consumed (ready=1) but produces wr_en=0; clip_err=1 in cycle N+1.
  - The fill engine never produces out-of-range writes.
- **Fill engine states: IDLE, RUN.**
  - IDLE→RUN on fill_start, latching: colour; x0, y0; x1e = min(x1, width-1); y1e = min(y1, height-1).
  - If x0>x1e or y0>y1e, the fill is empty: fill_done pulses next cycle and the engine stays IDLE with fill_busy=0.
  - RUN: fill_busy=1. Scan order is raster (cx from x0 to x1e, then cx=x0 and cy++), starting at (x0, y0). The position advances only when the fill slot is granted.
  - On the grant that issues (x1e, y1e), the engine returns to IDLE. fill_busy=0 and fill_done=1 coincide with that final wr_en cycle.
  - fill_start while RUN is ignored.
  - width/height changes during RUN do not affect the latched bounds.
- **Arithmetic.** Comparisons are unsigned COORD_W. Counters never wrap past the latched bounds.

Decomposition:
- Shared package vga_pkg holds:
  - constants COORD_W=10, PIX_W=3;
  - typedef coord_t (logic [COORD_W-1:0]);
  - typedef pix_t;
  - fill_state_t enum {IDLE, RUN}.
- Sub-module vga_fill_engine: latching, clamping, raster counters, busy/done.
- The arbiter, clip logic and output registers remain in vga_write_arbiter.

Test Plan:
1. Reset: assert srst asynchronously mid-cycle during a fill → wr_en, fill_busy, req_ready drop to 0 immediately; after release, no fill_done pulse and slot 0 wins first.
2. Single write: width=640, height=480, tear_free=0, req 0 sends (5,7,pixel=3) → req_ready[0]=1 same cycle; next cycle wr_en=1, X=5, Y=7, pixel=3; then wr_en=0.
3. Fairness: NREQ=2, both valid continuously for 4 cycles → grants 0,1,0,1; four consecutive wr_en cycles with matching coordinates.
4. Fill: fill (2,1)-(3,2), colour 5, no requesters → writes (2,1), (3,1), (2,2), (3,2) on consecutive cycles; fill_done=1 with the fourth wr_en. With req 0 also valid, fill and req 0 alternate and the fill takes 8 cycles.
5. Tear-free: tear_free=1, visible=1, req 0 valid → req_ready=0 for 10 cycles; visible→0 → grant that cycle, wr_en the next.
6. Clipping:
   - req (640,0) with width=640 → ready=1, wr_en stays 0, clip_err pulses once.
   - fill (638,0)-(700,0) → exactly 2 writes (638,0), (639,0), then fill_done.
   - fill with x0=5, x1=3 → no writes; fill_done next cycle.

Source files
------------

// File: rtl/vga_write_arbiter_pkg.sv
// Shared types and constants for the VGA frame-buffer write path.
package vga_pkg;

    localparam int COORD_W = 10;
    localparam int PIX_W   = 3;

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [PIX_W-1:0]   pix_t;

    typedef enum logic {
        IDLE,
        RUN
    } fill_state_t;

endpackage

// File: rtl/vga_write_arbiter_if.sv
// Pixel-writer request bundle: NREQ valid/ready channels carrying x, y and colour.
// The requesters drive the master side; the arbiter sits on the slave side.
interface vga_write_arbiter_if #(
    parameter int NREQ    = 2,
    parameter int COORD_W = vga_pkg::COORD_W,
    parameter int PIX_W   = vga_pkg::PIX_W
);

    logic [NREQ-1:0]              req_valid;
    logic [NREQ-1:0]              req_ready;
    logic [NREQ-1:0][COORD_W-1:0] req_x;
    logic [NREQ-1:0][COORD_W-1:0] req_y;
    logic [NREQ-1:0][PIX_W-1:0]   req_pixel;

    modport master (
        output req_valid, req_x, req_y, req_pixel,
        input  req_ready
    );

    modport slave (
        input  req_valid, req_x, req_y, req_pixel,
        output req_ready
    );

endinterface

// File: rtl/vga_write_arbiter_fill_engine.sv
// Rectangle-fill engine: latches a clamped rectangle and walks it in raster
// order, stepping one pixel each time the arbiter grants the fill slot.
module vga_fill_engine #(
    parameter int COORD_W = vga_pkg::COORD_W,
    parameter int PIX_W   = vga_pkg::PIX_W
) (
    input  logic               clk,
    input  logic               srst,
    input  logic [COORD_W-1:0] width,
    input  logic [COORD_W-1:0] height,
    input  logic               start,
    input  logic [COORD_W-1:0] x0,
    input  logic [COORD_W-1:0] y0,
    input  logic [COORD_W-1:0] x1,
    input  logic [COORD_W-1:0] y1,
    input  logic [PIX_W-1:0]   color,
    input  logic               advance,
    output logic               busy,
    output logic               done,
    output logic [COORD_W-1:0] cx,
    output logic [COORD_W-1:0] cy,
    output logic [PIX_W-1:0]   color_q
);
    import vga_pkg::*;

    fill_state_t        state, state_next;
    logic [COORD_W-1:0] x0_q, x1e_q, y1e_q;
    logic [COORD_W-1:0] x1_clamp, y1_clamp;
    logic               empty, last;

    // Clamp the far corner to the visible area and detect empty rectangles.
    always_comb begin
        x1_clamp = (x1 > width  - COORD_W'(1)) ? width  - COORD_W'(1) : x1;
        y1_clamp = (y1 > height - COORD_W'(1)) ? height - COORD_W'(1) : y1;
        // A zero-sized display would make width-1 wrap to all ones; treat it as empty.
        empty    = (width == '0) || (height == '0) || (x0 > x1_clamp) || (y0 > y1_clamp);
        last     = (cx == x1e_q) && (cy == y1e_q);
    end

    // State register.
    always_ff @(posedge clk or posedge srst) begin
        if (srst) state <= IDLE;
        else      state <= state_next;
    end

    // Next-state logic: leave IDLE on a non-empty start, return after the last pixel.
    always_comb begin
        // NOTE: assigning a default first keeps every path covered, so no latch is inferred.
        state_next = state;
        unique case (state)
            IDLE: if (start && !empty)  state_next = RUN;
            RUN:  if (advance && last)  state_next = IDLE;
            default:                    state_next = IDLE;
        endcase
    end

    // Latch the command on start, then advance the raster position on each grant.
    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            x0_q    <= '0;
            x1e_q   <= '0;
            y1e_q   <= '0;
            cx      <= '0;
            cy      <= '0;
            color_q <= '0;
            done    <= 1'b0;
        end else begin
            done <= ((state == RUN) && advance && last) ||
                    ((state == IDLE) && start && empty);
            if (state == IDLE) begin
                if (start) begin
                    x0_q    <= x0;
                    x1e_q   <= x1_clamp;
                    y1e_q   <= y1_clamp;
                    cx      <= x0;
                    cy      <= y0;
                    color_q <= color;
                end
            end else if (advance && !last) begin
                if (cx == x1e_q) begin
                    cx <= x0_q;
                    cy <= cy + COORD_W'(1);
                end else begin
                    cx <= cx + COORD_W'(1);
                end
            end
        end
    end

    assign busy = (state == RUN);

endmodule

// File: rtl/vga_write_arbiter.sv
// Round-robin arbiter for the frame-buffer write port. Slots 0..NREQ-1 are the
// external pixel writers, slot NREQ is the fill engine. Grants are held off in
// tear-free mode while the display is visible; out-of-range requester writes
// are consumed and dropped with a clip_err pulse. Outputs are registered.
module vga_write_arbiter #(
    parameter int NREQ    = 2,
    parameter int COORD_W = vga_pkg::COORD_W,
    parameter int PIX_W   = vga_pkg::PIX_W
) (
    input  logic               clk,
    input  logic               srst,
    input  logic [COORD_W-1:0] width,
    input  logic [COORD_W-1:0] height,
    input  logic               tear_free,
    input  logic               visible,
    vga_write_arbiter_if.slave req,
    input  logic               fill_start,
    input  logic [COORD_W-1:0] fill_x0,
    input  logic [COORD_W-1:0] fill_y0,
    input  logic [COORD_W-1:0] fill_x1,
    input  logic [COORD_W-1:0] fill_y1,
    input  logic [PIX_W-1:0]   fill_color,
    output logic               fill_busy,
    output logic               fill_done,
    output logic [COORD_W-1:0] X,
    output logic [COORD_W-1:0] Y,
    output logic               wr_en,
    output logic [PIX_W-1:0]   pixel,
    output logic               clip_err
);
    import vga_pkg::*;

    localparam int NSLOT = NREQ + 1;
    localparam int PTR_W = $clog2(NSLOT);

    logic [PTR_W-1:0]   ptr, sel, sel_hi, sel_lo;
    logic               gnt, gnt_hi, gnt_lo, fill_gnt, clip;
    logic [NSLOT-1:0]   elig;
    logic [COORD_W-1:0] sel_x, sel_y, fill_cx, fill_cy;
    logic [PIX_W-1:0]   sel_pix, fill_pix;

    vga_fill_engine #(.COORD_W(COORD_W), .PIX_W(PIX_W)) u_fill (
        .clk     (clk),
        .srst    (srst),
        .width   (width),
        .height  (height),
        .start   (fill_start),
        .x0      (fill_x0),
        .y0      (fill_y0),
        .x1      (fill_x1),
        .y1      (fill_y1),
        .color   (fill_color),
        .advance (fill_gnt),
        .busy    (fill_busy),
        .done    (fill_done),
        .cx      (fill_cx),
        .cy      (fill_cy),
        .color_q (fill_pix)
    );

    // Round-robin pick: first eligible slot above ptr, otherwise first at or below it.
    always_comb begin
        elig   = {fill_busy, req.req_valid} & {NSLOT{~(tear_free & visible) & ~srst}};
        gnt_hi = 1'b0;
        gnt_lo = 1'b0;
        sel_hi = '0;
        sel_lo = '0;
        for (int i = 0; i < NSLOT; i++) begin
            if (elig[i] && (PTR_W'(i) > ptr) && !gnt_hi) begin
                gnt_hi = 1'b1;
                sel_hi = PTR_W'(i);
            end
            if (elig[i] && (PTR_W'(i) <= ptr) && !gnt_lo) begin
                gnt_lo = 1'b1;
                sel_lo = PTR_W'(i);
            end
        end
        gnt      = gnt_hi | gnt_lo;
        sel      = gnt_hi ? sel_hi : sel_lo;
        fill_gnt = gnt && (sel == PTR_W'(NREQ));
    end

    // Ready strobes and the winning requester's payload with its clip decision.
    always_comb begin
        req.req_ready = '0;
        sel_x         = '0;
        sel_y         = '0;
        sel_pix       = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt && (sel == PTR_W'(i))) begin
                req.req_ready[i] = 1'b1;
                sel_x            = req.req_x[i];
                sel_y            = req.req_y[i];
                sel_pix          = req.req_pixel[i];
            end
        end
        clip = (sel_x >= width) || (sel_y >= height);
    end

    // Round-robin pointer moves only when a grant is issued.
    always_ff @(posedge clk or posedge srst) begin
        if (srst)     ptr <= PTR_W'(NREQ);
        else if (gnt) ptr <= sel;
    end

    // Registered frame-buffer port; coordinates and colour hold while idle.
    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            X        <= '0;
            Y        <= '0;
            pixel    <= '0;
            wr_en    <= 1'b0;
            clip_err <= 1'b0;
        end else begin
            wr_en    <= 1'b0;
            clip_err <= 1'b0;
            if (fill_gnt) begin
                X     <= fill_cx;
                Y     <= fill_cy;
                pixel <= fill_pix;
                wr_en <= 1'b1;
            end else if (gnt) begin
                if (clip) begin
                    clip_err <= 1'b1;
                end else begin
                    X     <= sel_x;
                    Y     <= sel_y;
                    pixel <= sel_pix;
                    wr_en <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_write_arbiter.sv
// Directed bench for vga_write_arbiter with NREQ=2 and a 640x480 display.
module tb_vga_write_arbiter;
    import vga_pkg::*;

    localparam int NREQ = 2;

    logic   clk = 1'b0;
    logic   srst;
    coord_t width, height;
    logic   tear_free, visible;
    logic   fill_start;
    coord_t fill_x0, fill_y0, fill_x1, fill_y1;
    pix_t   fill_color;
    logic   fill_busy, fill_done, wr_en, clip_err;
    coord_t fb_x, fb_y;
    pix_t   fb_pixel;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    vga_write_arbiter_if #(.NREQ(NREQ), .COORD_W(COORD_W), .PIX_W(PIX_W)) req_bus ();

    vga_write_arbiter #(.NREQ(NREQ), .COORD_W(COORD_W), .PIX_W(PIX_W)) dut (
        .clk        (clk),
        .srst       (srst),
        .width      (width),
        .height     (height),
        .tear_free  (tear_free),
        .visible    (visible),
        .req        (req_bus),
        .fill_start (fill_start),
        .fill_x0    (fill_x0),
        .fill_y0    (fill_y0),
        .fill_x1    (fill_x1),
        .fill_y1    (fill_y1),
        .fill_color (fill_color),
        .fill_busy  (fill_busy),
        .fill_done  (fill_done),
        .X          (fb_x),
        .Y          (fb_y),
        .wr_en      (wr_en),
        .pixel      (fb_pixel),
        .clip_err   (clip_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            failed++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input int x, input int y, input int p);
        req_bus.req_valid[i] = v;
        req_bus.req_x[i]     = COORD_W'(x);
        req_bus.req_y[i]     = COORD_W'(y);
        req_bus.req_pixel[i] = PIX_W'(p);
    endtask

    task automatic start_fill(input int x0, input int y0, input int x1, input int y1, input int c);
        fill_x0    = COORD_W'(x0);
        fill_y0    = COORD_W'(y0);
        fill_x1    = COORD_W'(x1);
        fill_y1    = COORD_W'(y1);
        fill_color = PIX_W'(c);
        fill_start = 1'b1;
    endtask

    task automatic check_wr(input string tag, input int x, input int y, input int p);
        check({tag, "_wr_en"}, 32'(wr_en), 32'd1);
        check({tag, "_x"},     32'(fb_x), x);
        check({tag, "_y"},     32'(fb_y), y);
        check({tag, "_pixel"}, 32'(fb_pixel), p);
    endtask

    initial begin
        srst       = 1'b1;
        width      = 10'd640;
        height     = 10'd480;
        tear_free  = 1'b0;
        visible    = 1'b0;
        fill_start = 1'b0;
        fill_x0 = '0; fill_y0 = '0; fill_x1 = '0; fill_y1 = '0; fill_color = '0;
        set_req(0, 1'b0, 0, 0, 0);
        set_req(1, 1'b0, 0, 0, 0);

        // Reset state
        #3;
        check("rst_wr_en",     32'(wr_en), 0);
        check("rst_fill_busy", 32'(fill_busy), 0);
        check("rst_fill_done", 32'(fill_done), 0);
        check("rst_clip_err",  32'(clip_err), 0);
        check("rst_ready",     32'(req_bus.req_ready), 0);
        check("rst_x",         32'(fb_x), 0);
        check("rst_y",         32'(fb_y), 0);
        check("rst_pixel",     32'(fb_pixel), 0);
        step();
        srst = 1'b0;
        step();

        // Fairness: both requesters valid for four cycles -> 0,1,0,1
        set_req(0, 1'b1, 10, 20, 1);
        set_req(1, 1'b1, 30, 40, 2);
        #1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("fair_ready%0d", k), 32'(req_bus.req_ready), (k % 2 == 1) ? 2 : 1);
            step();
            if (k == 3) req_bus.req_valid = '0;
            if (k % 2 == 1) check_wr($sformatf("fair%0d", k), 30, 40, 2);
            else            check_wr($sformatf("fair%0d", k), 10, 20, 1);
        end
        step();
        check("fair_idle_wr_en", 32'(wr_en), 0);

        // Single write from requester 0
        set_req(0, 1'b1, 5, 7, 3);
        #1;
        check("single_ready", 32'(req_bus.req_ready), 1);
        step();
        req_bus.req_valid = '0;
        check_wr("single", 5, 7, 3);
        step();
        check("single_after_wr_en", 32'(wr_en), 0);
        check("single_hold_x",      32'(fb_x), 5);

        // Fill (2,1)-(3,2) colour 5, no requesters
        start_fill(2, 1, 3, 2, 5);
        step();
        fill_start = 1'b0;
        check("fill_busy_start", 32'(fill_busy), 1);
        check("fill_start_wr_en", 32'(wr_en), 0);
        for (int k = 0; k < 4; k++) begin
            step();
            check_wr($sformatf("fill%0d", k), 2 + k % 2, 1 + k / 2, 5);
            check($sformatf("fill%0d_done", k), 32'(fill_done), (k == 3) ? 1 : 0);
            check($sformatf("fill%0d_busy", k), 32'(fill_busy), (k == 3) ? 0 : 1);
        end
        step();
        check("fill_end_wr_en", 32'(wr_en), 0);
        check("fill_end_done",  32'(fill_done), 0);

        // Same fill with requester 0 competing: strict alternation over 8 cycles
        start_fill(2, 1, 3, 2, 5);
        set_req(0, 1'b1, 20, 30, 6);
        for (int k = 0; k < 8; k++) begin
            #1;
            check($sformatf("mix%0d_ready", k), 32'(req_bus.req_ready), (k % 2 == 0) ? 1 : 0);
            step();
            if (k == 0) fill_start = 1'b0;
            if (k == 7) req_bus.req_valid = '0;
            if (k % 2 == 0) check_wr($sformatf("mix%0d", k), 20, 30, 6);
            else            check_wr($sformatf("mix%0d", k), 2 + (k / 2) % 2, 1 + k / 4, 5);
            check($sformatf("mix%0d_done", k), 32'(fill_done), (k == 7) ? 1 : 0);
        end
        step();
        check("mix_end_wr_en", 32'(wr_en), 0);

        // Tear-free hold while visible, grant as soon as visible drops
        tear_free = 1'b1;
        visible   = 1'b1;
        set_req(0, 1'b1, 9, 9, 4);
        for (int k = 0; k < 10; k++) begin
            #1;
            check($sformatf("tear%0d_ready", k), 32'(req_bus.req_ready), 0);
            step();
            check($sformatf("tear%0d_wr_en", k), 32'(wr_en), 0);
        end
        visible = 1'b0;
        #1;
        check("tear_release_ready", 32'(req_bus.req_ready), 1);
        step();
        req_bus.req_valid = '0;
        tear_free = 1'b0;
        check_wr("tear_release", 9, 9, 4);

        // Clipping: x == width on requester 0, y == height on requester 1
        set_req(0, 1'b1, 640, 0, 1);
        #1;
        check("clipx_ready", 32'(req_bus.req_ready), 1);
        step();
        req_bus.req_valid = '0;
        check("clipx_wr_en", 32'(wr_en), 0);
        check("clipx_err",   32'(clip_err), 1);
        check("clipx_hold_x", 32'(fb_x), 9);
        step();
        check("clipx_err_clear", 32'(clip_err), 0);
        set_req(1, 1'b1, 0, 480, 2);
        #1;
        check("clipy_ready", 32'(req_bus.req_ready), 2);
        step();
        req_bus.req_valid = '0;
        check("clipy_wr_en", 32'(wr_en), 0);
        check("clipy_err",   32'(clip_err), 1);
        step();
        check("clipy_err_clear", 32'(clip_err), 0);

        // Fill clamped at the right edge: only (638,0) and (639,0)
        start_fill(638, 0, 700, 0, 7);
        step();
        fill_start = 1'b0;
        step();
        check_wr("edge0", 638, 0, 7);
        check("edge0_done", 32'(fill_done), 0);
        step();
        check_wr("edge1", 639, 0, 7);
        check("edge1_done", 32'(fill_done), 1);
        step();
        check("edge_end_wr_en", 32'(wr_en), 0);
        check("edge_end_busy",  32'(fill_busy), 0);

        // Empty fill (x0 > x1): no writes, done the next cycle
        start_fill(5, 0, 3, 0, 1);
        step();
        fill_start = 1'b0;
        check("empty_done",  32'(fill_done), 1);
        check("empty_busy",  32'(fill_busy), 0);
        check("empty_wr_en", 32'(wr_en), 0);
        step();
        check("empty_done_clear", 32'(fill_done), 0);
        check("empty_wr_en2",     32'(wr_en), 0);

        // Asynchronous reset in the middle of a long fill
        start_fill(0, 0, 9, 9, 3);
        set_req(0, 1'b1, 3, 4, 2);
        #1;
        check("rfill_ready0", 32'(req_bus.req_ready), 1);
        step();
        fill_start = 1'b0;
        check_wr("rfill_req0", 3, 4, 2);
        check("rfill_ready1", 32'(req_bus.req_ready), 0);
        step();
        check_wr("rfill_fill0", 0, 0, 3);
        check("rfill_ready2", 32'(req_bus.req_ready), 1);
        step();
        set_req(1, 1'b1, 7, 8, 1);
        #1;
        check("rfill_pre_ready", 32'(req_bus.req_ready), 2);
        check("rfill_pre_busy",  32'(fill_busy), 1);
        check("rfill_pre_wr_en", 32'(wr_en), 1);
        #1;
        srst = 1'b1;
        #1;
        check("rfill_rst_wr_en", 32'(wr_en), 0);
        check("rfill_rst_busy",  32'(fill_busy), 0);
        check("rfill_rst_ready", 32'(req_bus.req_ready), 0);
        check("rfill_rst_x",     32'(fb_x), 0);
        step();
        check("rfill_rst_hold_wr_en", 32'(wr_en), 0);
        srst = 1'b0;
        #1;
        check("rfill_post_ready", 32'(req_bus.req_ready), 1);
        step();
        req_bus.req_valid = '0;
        check_wr("rfill_post", 3, 4, 2);
        check("rfill_post_done", 32'(fill_done), 0);
        check("rfill_post_busy", 32'(fill_busy), 0);
        step();
        check("rfill_idle_wr_en", 32'(wr_en), 0);
        check("rfill_idle_done",  32'(fill_done), 0);
        check("rfill_idle_busy",  32'(fill_busy), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
